// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared constants, state encoding and write-entry type for the frame-buffer arbiter
package fb_pkg;

  localparam int H_ACTIVE    = 640;
  localparam int V_ACTIVE    = 480;
  localparam int ROW_W       = 9;
  localparam int COL_W       = 10;
  localparam int ADDR_W      = 19;
  localparam int PIX_W       = 12;
  localparam int WFIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } fb_state_e;

  // 31-bit buffered write: {row, col, data}
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/fb_wr_fifo.sv
// rtl/fb_wr_fifo.sv - small write FIFO buffering game-logic pixel writes
// Ports:
//   vga_clk, clrn : clock, async active-low reset
//   flush         : empties the FIFO; wins over push and pop in the same cycle
//   push, din     : store din when not full
//   pop, dout     : dout is the head entry; pop discards it when not empty
//   full, empty   : occupancy flags, decoded from the registered count
module fb_wr_fifo
  import fb_pkg::*;
(
  input  logic      vga_clk,
  input  logic      clrn,
  input  logic      flush,
  input  logic      push,
  input  wr_entry_t din,
  input  logic      pop,
  output wr_entry_t dout,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(WFIFO_DEPTH);

  wr_entry_t        mem_q [WFIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full  = (cnt_q == (PTR_W+1)'(WFIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign dout  = mem_q[rptr_q];

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (flush) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      cnt_d = cnt_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Storage needs no reset: the count alone decides what is valid.
  always_ff @(posedge vga_clk) begin
    if (do_push) mem_q[wptr_q] <= din;
  end

endmodule

// File: rtl/fb_arbiter.sv
// rtl/fb_arbiter.sv - single-port frame-buffer arbiter: display reads, buffered writes, full-screen clear
// Ports:
//   vga_clk, clrn                      : pixel clock, async active-low reset
//   vga_rdn, vga_row, vga_col, vga_din : display read (active-low request), pixel returned same cycle
//   wr_valid/wr_ready/wr_row/wr_col/wr_data : game-logic pixel write channel
//   clr_req, clr_color, clr_busy, clr_done  : screen-clear request and status
//   ram_addr, ram_we, ram_wdata, ram_rdata  : single-port pixel RAM with combinational read
// H_VIS/V_VIS set the visible area; they default to the full VGA frame.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int H_VIS = H_ACTIVE,
  parameter int V_VIS = V_ACTIVE
) (
  input  logic              vga_clk,
  input  logic              clrn,
  input  logic              vga_rdn,
  input  logic [ROW_W-1:0]  vga_row,
  input  logic [COL_W-1:0]  vga_col,
  output logic [PIX_W-1:0]  vga_din,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              clr_req,
  input  logic [PIX_W-1:0]  clr_color,
  output logic              clr_busy,
  output logic              clr_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata
);

  localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(V_VIS);
  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(H_VIS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_VIS - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_VIS - 1);

  fb_state_e        state_q, state_d;
  logic [ROW_W-1:0] crow_q, crow_d;
  logic [COL_W-1:0] ccol_q, ccol_d;
  logic [PIX_W-1:0] color_q, color_d;
  logic             done_q, done_d;

  wr_entry_t fifo_din, fifo_head;
  logic      fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic      in_range, clr_start;

  assign in_range  = (wr_row < ROW_LIM) && (wr_col < COL_LIM);
  assign clr_start = (state_q == ST_IDLE) && clr_req;

  // Out-of-range writes still handshake (wr_ready) but never reach storage.
  assign fifo_push  = wr_valid & ~fifo_full & in_range;
  assign fifo_flush = clr_start;
  assign fifo_pop   = (state_q == ST_IDLE) & vga_rdn & ~fifo_empty;
  assign fifo_din   = '{row: wr_row, col: wr_col, data: wr_data};

  fb_wr_fifo u_wr_fifo (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .din     (fifo_din),
    .pop     (fifo_pop),
    .dout    (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign wr_ready = ~fifo_full;
  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = done_q;
  assign vga_din  = ram_rdata;

  // RAM port depends only on vga_rdn and registered state.
  always_comb begin
    ram_addr  = {vga_row, vga_col};
    ram_we    = 1'b0;
    ram_wdata = fifo_head.data;
    if (vga_rdn) begin
      if (state_q == ST_CLEAR) begin
        ram_addr  = {crow_q, ccol_q};
        ram_we    = 1'b1;
        ram_wdata = color_q;
      end else if (!fifo_empty) begin
        ram_addr  = {fifo_head.row, fifo_head.col};
        ram_we    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    crow_d  = crow_q;
    ccol_d  = ccol_q;
    color_d = color_q;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      if (clr_req) begin
        state_d = ST_CLEAR;
        crow_d  = '0;
        ccol_d  = '0;
        color_d = clr_color;
      end
    end else if (vga_rdn) begin
      if (ccol_q == COL_LAST) begin
        ccol_d = '0;
        if (crow_q == ROW_LAST) begin
          state_d = ST_IDLE;
          crow_d  = '0;
          done_d  = 1'b1;
        end else begin
          crow_d = crow_q + ROW_W'(1);
        end
      end else begin
        ccol_d = ccol_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge vga_clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= ST_IDLE;
      crow_q  <= '0;
      ccol_q  <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      crow_q  <= crow_d;
      ccol_q  <= ccol_d;
      color_q <= color_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb/tb_fb_arbiter.sv - scoreboard bench for fb_arbiter on a reduced visible area
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int HV = 24;
  localparam int VV = 8;
  localparam int HT = 32;
  localparam int VT = 10;

  logic        vga_clk, clrn, vga_rdn;
  logic [8:0]  vga_row, wr_row;
  logic [9:0]  vga_col, wr_col;
  logic [11:0] vga_din, wr_data, clr_color, ram_wdata, ram_rdata;
  logic        wr_valid, wr_ready, clr_req, clr_busy, clr_done, ram_we;
  logic [18:0] ram_addr;

  bit [11:0] ram [0:(1<<19)-1];
  assign ram_rdata = ram[ram_addr];

  fb_arbiter #(.H_VIS(HV), .V_VIS(VV)) dut (
    .vga_clk(vga_clk), .clrn(clrn), .vga_rdn(vga_rdn), .vga_row(vga_row), .vga_col(vga_col),
    .vga_din(vga_din), .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .clr_req(clr_req), .clr_color(clr_color),
    .clr_busy(clr_busy), .clr_done(clr_done), .ram_addr(ram_addr), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  int checks = 0, failures = 0;
  logic [30:0] sb [$];
  int hc = 0, vc = 0;
  bit vga_run = 0;
  int exp_crow = 0, exp_ccol = 0;
  logic [11:0] exp_color = '0;
  int clr_err = 0, clr_wr_cnt = 0, unexp = 0, rd_conflict = 0, done_cnt = 0, busy_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Observe the RAM port mid-cycle; update the RAM model as the write lands.
  always @(negedge vga_clk) begin
    if (clrn) begin
      if (ram_we && !vga_rdn) rd_conflict++;
      if (ram_we) begin
        if (clr_busy) begin
          if (ram_addr !== {9'(exp_crow), 10'(exp_ccol)} || ram_wdata !== exp_color) clr_err++;
          clr_wr_cnt++;
          if (exp_ccol == HV - 1) begin
            exp_ccol = 0;
            exp_crow++;
          end else begin
            exp_ccol++;
          end
        end else if (sb.size() == 0) begin
          unexp++;
        end else begin
          chk("fifo_wr", {1'b0, ram_addr, ram_wdata}, {1'b0, sb.pop_front()});
        end
        ram[ram_addr] = ram_wdata;
      end
      if (clr_done) done_cnt++;
      if (clr_busy) busy_cyc++;
    end
  end

  task automatic drive_vga();
    vga_rdn = !(hc < HV && vc < VV);
    vga_row = 9'(vc);
    vga_col = 10'(hc);
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
    if (vga_run) begin
      hc++;
      if (hc == HT) begin
        hc = 0;
        vc = (vc + 1) % VT;
      end
      drive_vga();
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int r, input int c, input logic [11:0] d, input bit keep,
                    input bit with_clr, input logic [11:0] ccolor);
    bit acc, rdy;
    wr_row = 9'(r); wr_col = 10'(c); wr_data = d; wr_valid = 1'b1;
    if (with_clr) begin
      clr_req = 1'b1; clr_color = ccolor;
      exp_crow = 0; exp_ccol = 0; exp_color = ccolor;
    end
    acc = 0;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge vga_clk);
      rdy = wr_ready;
      tick();
      clr_req = 1'b0;
      if (rdy) acc = 1;
    end
    wr_valid = 1'b0;
    chk("wr_accept", 32'(acc), 32'd1);
    if (acc && keep) sb.push_back({9'(r), 10'(c), d});
  endtask

  task automatic clr_pulse(input logic [11:0] color, input bit fresh);
    clr_req = 1'b1; clr_color = color;
    if (fresh) begin
      exp_crow = 0; exp_ccol = 0; exp_color = color;
    end
    tick();
    clr_req = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int n = 0; n < 3000 && !seen; n++) begin
      @(negedge vga_clk);
      if (clr_done) seen = 1;
      tick();
    end
    chk("clr_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic verify_pix(input logic [11:0] color, input bit skip_en, input logic [18:0] skip);
    int errs = 0;
    for (int r = 0; r < VV; r++)
      for (int c = 0; c < HV; c++)
        if (!(skip_en && {9'(r), 10'(c)} == skip) && ram[{9'(r), 10'(c)}] !== color) errs++;
    chk("clear_pix", 32'(errs), 32'd0);
  endtask

  initial begin
    clrn = 1'b0; vga_rdn = 1'b1; vga_row = '0; vga_col = '0;
    wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    clr_req = 1'b0; clr_color = '0;
    #3;
    chk("rst_busy", 32'(clr_busy), 32'd0);
    chk("rst_done", 32'(clr_done), 32'd0);
    chk("rst_ready", 32'(wr_ready), 32'd1);
    chk("rst_we", 32'(ram_we), 32'd0);
    #10;
    @(negedge vga_clk);
    clrn = 1'b1;
    tick();

    // display read has priority and zero latency
    ram[{9'd5, 10'd7}] = 12'hABC;
    vga_rdn = 1'b0; vga_row = 9'd5; vga_col = 10'd7;
    #1;
    chk("rd_addr", 32'(ram_addr), 32'h01407);
    chk("rd_we", 32'(ram_we), 32'd0);
    chk("rd_din", 32'(vga_din), 32'hABC);

    // fill the FIFO while the display holds the port
    wr(1, 1, 12'h111, 1, 0, '0);
    wr(1, 2, 12'h222, 1, 0, '0);
    wr(2, 3, 12'h333, 1, 0, '0);
    wr(3, 4, 12'h444, 1, 0, '0);
    chk("full_ready", 32'(wr_ready), 32'd0);
    wr_row = 9'd4; wr_col = 10'd5; wr_data = 12'h555; wr_valid = 1'b1;
    ticks(2);
    chk("held_ready", 32'(wr_ready), 32'd0);
    vga_rdn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bit rdy;
      @(negedge vga_clk);
      chk("drain_we", 32'(ram_we), 32'd1);
      rdy = wr_ready;
      tick();
      if (wr_valid && rdy) begin
        sb.push_back({9'd4, 10'd5, 12'h555});
        wr_valid = 1'b0;
      end
    end
    chk("fifth_taken", 32'(wr_valid), 32'd0);
    ticks(3);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    // out-of-range writes are accepted and dropped
    wr(480, 0, 12'hBAD, 0, 0, '0);
    wr(0, 640, 12'hBAD, 0, 0, '0);
    ticks(4);
    chk("oor_unexp", 32'(unexp), 32'd0);
    chk("oor_ready", 32'(wr_ready), 32'd1);
    chk("oor_ram", 32'(ram[{9'd480, 10'd0}]), 32'd0);

    // full clear under a running display timing stream
    hc = 0; vc = 0; vga_run = 1; drive_vga();
    busy_cyc = 0; clr_wr_cnt = 0;
    clr_pulse(12'hFFF, 1);
    wait_done();
    chk("done_cnt1", 32'(done_cnt), 32'd1);
    chk("clr_wr_cnt", 32'(clr_wr_cnt), 32'(HV * VV));
    chk("busy_span", 32'(busy_cyc >= HV * VV && busy_cyc <= 2 * HT * VT), 32'd1);
    chk("clr_seq1", 32'(clr_err), 32'd0);
    verify_pix(12'hFFF, 0, '0);

    // queued writes flushed by clear; mid-clear write survives; mid-clear clr_req ignored
    vga_run = 0; vga_rdn = 1'b0;
    wr(1, 1, 12'hE01, 0, 0, '0);
    wr(1, 2, 12'hE02, 0, 0, '0);
    wr(1, 3, 12'hE03, 0, 0, '0);
    wr(3, 3, 12'hE04, 0, 1, 12'h5A5);
    vga_run = 1; drive_vga();
    ticks(20);
    chk("mid_busy", 32'(clr_busy), 32'd1);
    wr(2, 2, 12'h123, 1, 0, '0);
    clr_pulse(12'h0F0, 0);
    wait_done();
    ticks(64);
    chk("done_cnt2", 32'(done_cnt), 32'd2);
    chk("survivor", 32'(ram[{9'd2, 10'd2}]), 32'h123);
    chk("sb_empty2", 32'(sb.size()), 32'd0);
    verify_pix(12'h5A5, 1, {9'd2, 10'd2});

    // reset mid-clear abandons it; next clear restarts at (0,0)
    clr_pulse(12'h00F, 1);
    ticks(30);
    chk("pre_rst_busy", 32'(clr_busy), 32'd1);
    #2;
    clrn = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(clr_busy), 32'd0);
    chk("rst_mid_ready", 32'(wr_ready), 32'd1);
    @(negedge vga_clk);
    clrn = 1'b1;
    ticks(5);
    chk("no_done_rst", 32'(done_cnt), 32'd2);
    clr_pulse(12'h777, 1);
    wait_done();
    chk("done_cnt3", 32'(done_cnt), 32'd3);
    verify_pix(12'h777, 0, '0);

    chk("clr_seq_all", 32'(clr_err), 32'd0);
    chk("rd_conflict", 32'(rd_conflict), 32'd0);
    chk("unexp_wr", 32'(unexp), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
